// File: rtl/alu32_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu32_pkg
// Purpose  : Shared ALU op encodings, flag bit indices and entry field widths.
// Revision : 1.0 - initial release
// ============================================================================
package alu32_pkg;

    localparam logic [2:0] OP_NOTA = 3'b000;
    localparam logic [2:0] OP_NOTB = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_ADD  = 3'b110;
    localparam logic [2:0] OP_SUB  = 3'b111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int OP_W   = 3;
    localparam int NZCV_W = 4;

    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage : alu32_pkg
`default_nettype wire

// File: rtl/alu32_buf_mem.sv
`default_nettype none
// ============================================================================
// Module   : alu32_buf_mem
// Purpose  : DEPTH x (WIDTH+op+nzcv) storage, synchronous write, async read.
// Revision : 1.0 - initial release
// ============================================================================
module alu32_buf_mem
    import alu32_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               wr_en,
    input  logic [$clog2(DEPTH)-1:0]           wr_ptr,
    input  logic [WIDTH+OP_W+NZCV_W-1:0]       wr_data,
    input  logic [$clog2(DEPTH)-1:0]           rd_ptr,
    output logic [WIDTH+OP_W+NZCV_W-1:0]       rd_data
);

    localparam int C_ENTRY_W = WIDTH + OP_W + NZCV_W;

    // Storage carries no reset: validity is tracked entirely by the top's count.
    logic [C_ENTRY_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr];

endmodule : alu32_buf_mem
`default_nettype wire

// File: rtl/alu32_result_buf.sv
`default_nettype none
// ============================================================================
// Module   : alu32_result_buf
// Purpose  : Valid/ready FIFO behind the 32-bit ALU plus architectural NZCV.
//            Optional sticky overflow enabled by macro ALU32_STICKY_V_EN.
// Revision : 1.0 - initial release
// ============================================================================
module alu32_result_buf
    import alu32_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 in_op,
    input  logic [WIDTH-1:0]           in_result,
    input  logic                       in_n,
    input  logic                       in_z,
    input  logic                       in_c,
    input  logic                       in_v,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2:0]                 out_op,
    output logic [WIDTH-1:0]           out_result,
    output logic [3:0]                 out_nzcv,
    output logic [$clog2(DEPTH):0]     count,
    output logic [3:0]                 flag_nzcv,
    output logic                       sticky_v
);

    localparam int                C_PTR_W   = $clog2(DEPTH);
    localparam int                C_CNT_W   = C_PTR_W + 1;
    localparam int                C_ENTRY_W = WIDTH + OP_W + NZCV_W;
    localparam logic [C_CNT_W-1:0] C_FULL   = C_CNT_W'(DEPTH);

    logic [C_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [C_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [C_CNT_W-1:0]   count_q,  count_d;
    logic [3:0]           flags_q,  flags_d;
    logic                 push, pop;
    logic [C_ENTRY_W-1:0] wr_data, rd_data;

    // Handshake depends on registered occupancy only.
    assign in_ready  = (count_q != C_FULL);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    assign wr_data = {in_op, in_result, in_n, in_z, in_c, in_v};

    alu32_buf_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_ptr  (wr_ptr_q),
        .wr_data (wr_data),
        .rd_ptr  (rd_ptr_q),
        .rd_data (rd_data)
    );

    assign out_op     = rd_data[C_ENTRY_W-1 -: OP_W];
    assign out_result = rd_data[NZCV_W +: WIDTH];
    assign out_nzcv   = rd_data[NZCV_W-1:0];
    assign count      = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + C_PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + C_PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + C_CNT_W'(1);
                2'b01:   count_d = count_q - C_CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Flags follow issue order; logic ops leave C and V untouched.
    always_comb begin
        flags_d = flags_q;
        if (push) begin
            flags_d[FLAG_N] = in_n;
            flags_d[FLAG_Z] = in_z;
            if (is_arith(in_op)) begin
                flags_d[FLAG_C] = in_c;
                flags_d[FLAG_V] = in_v;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            flags_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            flags_q  <= flags_d;
        end
    end

`ifdef ALU32_STICKY_V_EN
    logic sticky_v_q, sticky_v_d;

    always_comb begin
        sticky_v_d = sticky_v_q | (push & is_arith(in_op) & in_v);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sticky_v_q <= 1'b0;
        end else begin
            sticky_v_q <= sticky_v_d;
        end
    end

    assign sticky_v  = sticky_v_q;
    assign flag_nzcv = {flags_q[3:1], flags_q[FLAG_V] | sticky_v_q};
`else
    assign sticky_v  = 1'b0;
    assign flag_nzcv = flags_q;
`endif

endmodule : alu32_result_buf
`default_nettype wire

// File: tb/tb_alu32_result_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu32_result_buf
// Purpose  : Scoreboard bench for alu32_result_buf (WIDTH=32, DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu32_result_buf;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] result;
        logic [3:0]  nzcv;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = 3'b000;
    logic [31:0] in_result = '0;
    logic        in_n = 1'b0, in_z = 1'b0, in_c = 1'b0, in_v = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [2:0]  out_op;
    logic [31:0] out_result;
    logic [3:0]  out_nzcv;
    logic [2:0]  count;
    logic [3:0]  flag_nzcv;
    logic        sticky_v;

    int   n_checks = 0;
    int   n_errors = 0;
    ent_t exp_q[$];
    logic [3:0] m_flags  = 4'b0000;
    logic       m_sticky = 1'b0;

    alu32_result_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_result  (in_result),
        .in_n       (in_n),
        .in_z       (in_z),
        .in_c       (in_c),
        .in_v       (in_v),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_op     (out_op),
        .out_result (out_result),
        .out_nzcv   (out_nzcv),
        .count      (count),
        .flag_nzcv  (flag_nzcv),
        .sticky_v   (sticky_v)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] exp_flag_out();
`ifdef ALU32_STICKY_V_EN
        return {m_flags[3:1], m_flags[0] | m_sticky};
`else
        return m_flags;
`endif
    endfunction

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] res,
                         input logic [3:0] nzcv);
        in_valid  = v;
        in_op     = op;
        in_result = res;
        {in_n, in_z, in_c, in_v} = nzcv;
    endtask

    // Advances one cycle; model decisions come from the queue, not the DUT.
    task automatic tick();
        logic do_push, do_pop;
        do_push = in_valid && (exp_q.size() < DEPTH) && !flush;
        do_pop  = out_ready && (exp_q.size() > 0) && !flush;
        @(posedge clk);
        if (flush) begin
            exp_q.delete();
        end else begin
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) begin
                exp_q.push_back('{op: in_op, result: in_result, nzcv: {in_n, in_z, in_c, in_v}});
                m_flags[3] = in_n;
                m_flags[2] = in_z;
                if (in_op == 3'b110 || in_op == 3'b111) begin
                    m_flags[1] = in_c;
                    m_flags[0] = in_v;
`ifdef ALU32_STICKY_V_EN
                    if (in_v) m_sticky = 1'b1;
`endif
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 ||
            flag_nzcv !== 4'b0000 || sticky_v !== 1'b0) begin
            n_errors++;
            $display("FAIL reset: count=%0d out_valid=%b in_ready=%b flags=%b sticky=%b, expected 0/0/1/0000/0",
                     count, out_valid, in_ready, flag_nzcv, sticky_v);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        drive(1'b1, 3'b110, 32'h0000_0005, 4'b0000);
        tick();
        drive(1'b0, 3'b000, '0, 4'b0000);
        n_checks++;
        if (out_valid !== 1'b1 || out_result !== 32'd5 || flag_nzcv !== 4'b0000 || count !== 3'd1) begin
            n_errors++;
            $display("FAIL single_latency: valid=%b result=%h flags=%b count=%0d, expected 1/5/0000/1",
                     out_valid, out_result, flag_nzcv, count);
        end
        out_ready = 1'b1;
        if (out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0 || {out_op, out_result, out_nzcv} !== exp_q[0]) begin
                n_errors++;
                $display("FAIL single_head: got %h, expected %h", {out_op, out_result, out_nzcv},
                         exp_q.size() ? exp_q[0] : 'x);
            end
        end
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL single_pop: count=%0d valid=%b, expected 0/0", count, out_valid);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 3'(i), 32'h0000_0100 + 32'(i), 4'(i * 5));
            tick();
        end
        n_checks++;
        if (in_ready !== 1'b0 || count !== 3'd4) begin
            n_errors++;
            $display("FAIL fill_full: in_ready=%b count=%0d, expected 0/4", in_ready, count);
        end
        drive(1'b1, 3'b110, 32'hDEAD_BEEF, 4'b1111);
        tick();
        drive(1'b0, 3'b000, '0, 4'b0000);
        n_checks++;
        if (count !== 3'd4 || flag_nzcv !== exp_flag_out()) begin
            n_errors++;
            $display("FAIL fill_reject: count=%0d flags=%b, expected 4/%b", count, flag_nzcv, exp_flag_out());
        end
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || exp_q.size() == 0 || {out_op, out_result, out_nzcv} !== exp_q[0] ||
                out_result !== 32'h0000_0100 + 32'(i)) begin
                n_errors++;
                $display("FAIL fill_drain[%0d]: valid=%b got %h, expected result %h", i, out_valid,
                         {out_op, out_result, out_nzcv}, 32'h0000_0100 + 32'(i));
            end
            tick();
        end
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            n_errors++;
            $display("FAIL fill_empty: valid=%b count=%0d, expected 0/0", out_valid, count);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 3'b011, 32'(i), 4'b0100);
            n_checks++;
            if (count !== ((i == 1) ? 3'd0 : 3'd1)) begin
                n_errors++;
                $display("FAIL stream_count[%0d]: count=%0d, expected %0d", i, count, (i == 1) ? 0 : 1);
            end
            if (i > 1) begin
                n_checks++;
                if (out_valid !== 1'b1 || exp_q.size() == 0 || {out_op, out_result, out_nzcv} !== exp_q[0] ||
                    out_result !== 32'(i - 1)) begin
                    n_errors++;
                    $display("FAIL stream_head[%0d]: valid=%b result=%h, expected %h", i, out_valid,
                             out_result, 32'(i - 1));
                end
            end
            tick();
        end
        drive(1'b0, 3'b000, '0, 4'b0000);
        n_checks++;
        if (out_valid !== 1'b1 || out_result !== 32'd10) begin
            n_errors++;
            $display("FAIL stream_last: valid=%b result=%h, expected 1/0000000a", out_valid, out_result);
        end
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (count !== 3'd0 || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL stream_end: count=%0d, expected 0", count);
        end
    endtask

    task automatic test_flags();
        out_ready = 1'b1;
        drive(1'b1, 3'b111, 32'h1, 4'b0011);
        tick();
        drive(1'b1, 3'b010, 32'h2, 4'b1000);
        tick();
        drive(1'b0, 3'b000, '0, 4'b0000);
        n_checks++;
        if (flag_nzcv !== 4'b1011 || flag_nzcv !== exp_flag_out()) begin
            n_errors++;
            $display("FAIL flag_hold: flags=%b, expected 1011", flag_nzcv);
        end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        logic [3:0] flags_before;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'b110, 32'h0000_0A00 + 32'(i), 4'b0110);
            tick();
        end
        flags_before = exp_flag_out();
        n_checks++;
        if (count !== 3'd3 || flag_nzcv !== flags_before) begin
            n_errors++;
            $display("FAIL flush_pre: count=%0d flags=%b, expected 3/%b", count, flag_nzcv, flags_before);
        end
        drive(1'b1, 3'b111, 32'h0000_0777, 4'b1101);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 3'b000, '0, 4'b0000);
        n_checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || flag_nzcv !== flags_before) begin
            n_errors++;
            $display("FAIL flush: count=%0d valid=%b ready=%b flags=%b, expected 0/0/1/%b",
                     count, out_valid, in_ready, flag_nzcv, flags_before);
        end
        drive(1'b1, 3'b100, 32'h0000_0B0B, 4'b0000);
        tick();
        drive(1'b0, 3'b000, '0, 4'b0000);
        out_ready = 1'b1;
        n_checks++;
        if (out_valid !== 1'b1 || count !== 3'd1 || out_result !== 32'h0000_0B0B ||
            exp_q.size() == 0 || {out_op, out_result, out_nzcv} !== exp_q[0]) begin
            n_errors++;
            $display("FAIL flush_after: valid=%b count=%0d result=%h, expected 1/1/00000b0b",
                     out_valid, count, out_result);
        end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_sticky();
        reset_n = 1'b0;
        exp_q.delete();
        m_flags = 4'b0000;
        m_sticky = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        drive(1'b1, 3'b110, 32'h10, 4'b0001);
        tick();
        drive(1'b1, 3'b110, 32'h11, 4'b0000);
        tick();
        drive(1'b0, 3'b000, '0, 4'b0000);
        n_checks++;
`ifdef ALU32_STICKY_V_EN
        if (sticky_v !== 1'b1 || flag_nzcv[0] !== 1'b1 || flag_nzcv !== exp_flag_out()) begin
            n_errors++;
            $display("FAIL sticky: sticky=%b flags=%b, expected 1/0001", sticky_v, flag_nzcv);
        end
`else
        if (sticky_v !== 1'b0 || flag_nzcv[0] !== 1'b0 || flag_nzcv !== exp_flag_out()) begin
            n_errors++;
            $display("FAIL sticky: sticky=%b flags=%b, expected 0/0000", sticky_v, flag_nzcv);
        end
`endif
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 3'b111, 32'h55, 4'b1111);
        tick();
        tick();
        #2 reset_n = 1'b0;
        #1;
        exp_q.delete();
        m_flags = 4'b0000;
        m_sticky = 1'b0;
        n_checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || flag_nzcv !== 4'b0000 || sticky_v !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid: count=%0d valid=%b flags=%b sticky=%b, expected 0/0/0000/0",
                     count, out_valid, flag_nzcv, sticky_v);
        end
        drive(1'b0, 3'b000, '0, 4'b0000);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_flags();
        test_flush();
        test_sticky();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_alu32_result_buf
`default_nettype wire
